load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 48 ++++
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, RV32I funct3
// width codes and the request legality check.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACCESS    = 2'd1,
    S_RMW_WRITE = 2'd2,
    S_DONE      = 2'd3
  } lsu_state_e;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Returns 1 when a request must complete with err instead of touching memory:
  // an unknown funct3 for the direction, or a half/word access that is misaligned.
  function automatic logic lsu_illegal(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
    logic bad_code;
    logic misaligned;
    if (we) begin
      bad_code = (f3 > F3_SW);
    end else begin
      bad_code = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                 ((f3[1:0] == 2'b10) && (off != 2'b00));
    return bad_code || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load result from the
// addressed word, and merges store byte/half data into the read word.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection shared by the load extension
  always_comb begin
    byte_v = mem_rdata_i[{off_i, 3'b000} +: 8];
    half_v = off_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  end

  // Load extraction with sign or zero extension
  always_comb begin
    load_o = mem_rdata_i;
    case (funct3_i)
      F3_LB:   load_o = {{24{byte_v[7]}}, byte_v};
      F3_LH:   load_o = {{16{half_v[15]}}, half_v};
      F3_LBU:  load_o = {24'd0, byte_v};
      F3_LHU:  load_o = {16'd0, half_v};
      default: load_o = mem_rdata_i;
    endcase
  end

  // Sub-word store merge into the current memory word
  always_comb begin
    merge_o = mem_rdata_i;
    case (funct3_i)
      F3_SB: merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_SH: begin
        if (off_i[1]) merge_o[31:16] = wdata_i;
        else          merge_o[15:0]  = wdata_i;
      end
      default: merge_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time and performs it against
// a 64-word data memory, using read-modify-write for byte/half stores.
// Handshake: req is sampled only in IDLE; busy is high from the cycle after
// acceptance until done; done is a single-cycle pulse and err is only
// meaningful while done is high.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        err_q;
  logic        mem_read_q;
  logic        mem_write_q;

  logic [31:0] load_val;
  logic [31:0] merge_val;
  logic        unused_addr_hi;

  // Only a 256-byte window is addressable; the upper address bits wrap.
  assign unused_addr_hi = ^addr[31:8];

  lsu_align u_align (
    .funct3_i    (f3_q),
    .off_i       (addr_q[1:0]),
    .mem_rdata_i (mem_rdata),
    .wdata_i     (wdata_q[15:0]),
    .load_o      (load_val),
    .merge_o     (merge_val)
  );

  // Request FSM with registered memory strobes and completion flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 8'd0;
      wdata_q     <= 32'd0;
      merge_q     <= 32'd0;
      rdata_q     <= 32'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            f3_q    <= funct3;
            addr_q  <= addr[7:0];
            wdata_q <= wdata;
            if (lsu_illegal(we, funct3, addr[1:0])) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_ACCESS;
              // Word stores write directly; loads and sub-word stores read first.
              if (we && (funct3 == F3_SW)) mem_write_q <= 1'b1;
              else                         mem_read_q  <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (!we_q) begin
            rdata_q <= load_val;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (f3_q == F3_SW) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            merge_q     <= merge_val;
            mem_write_q <= 1'b1;
            state_q     <= S_RMW_WRITE;
          end
        end
        S_RMW_WRITE: begin
          mem_write_q <= 1'b0;
          state_q     <= S_DONE;
          done_q      <= 1'b1;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q[7:2];
  // The merged word is only presented during the write-back phase.
  assign mem_wdata = (state_q == S_RMW_WRITE) ? merge_q : wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word memory model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];

  int checks;
  int failures;

  // Results of the most recent do_access call
  int          r_lat;
  int          r_nrd;
  int          r_nwr;
  logic        r_err;
  logic        r_overlap;
  logic [5:0]  r_waddr;
  logic [31:0] r_wdata;

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: combinational read, write committed at the clock edge
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  // Driver: one request, then observe each cycle until done or 12 cycles pass.
  // r_lat counts cycles after the accept cycle; -1 means done never came.
  task automatic do_access(input logic a_we, input logic [2:0] a_f3,
                           input logic [31:0] a_addr, input logic [31:0] a_wdata);
    r_lat = -1; r_nrd = 0; r_nwr = 0; r_err = 1'b0; r_overlap = 1'b0;
    r_waddr = '0; r_wdata = '0;
    @(negedge clk);
    req = 1'b1; we = a_we; funct3 = a_f3; addr = a_addr; wdata = a_wdata;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_read && mem_write) r_overlap = 1'b1;
      if (mem_read) r_nrd++;
      if (mem_write) begin
        r_nwr++;
        r_waddr = mem_addr;
        r_wdata = mem_wdata;
      end
      if (done) begin
        r_lat = k;
        r_err = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
    checks++; if (mem_addr !== 6'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
    checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=00000000", mem_wdata); end
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads();
    do_access(1'b0, F3_LB, 32'h08, 32'h0);
    checks++; if (rdata !== 32'h00000019) begin failures++; $display("FAIL lb08_rdata got=%h exp=00000019", rdata); end
    checks++; if (r_lat !== 2) begin failures++; $display("FAIL lb08_latency got=%0d exp=2", r_lat); end
    checks++; if (r_nrd !== 1 || r_nwr !== 0) begin failures++; $display("FAIL lb08_strobes got rd=%0d wr=%0d exp rd=1 wr=0", r_nrd, r_nwr); end
    checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL lb08_err got=%b exp=0", r_err); end

    do_access(1'b0, F3_LB, 32'h09, 32'h0);
    checks++; if (rdata !== 32'hFFFFFFFF) begin failures++; $display("FAIL lb09_rdata got=%h exp=ffffffff", rdata); end

    do_access(1'b0, F3_LH, 32'h0A, 32'h0);
    checks++; if (rdata !== 32'hFFFF8000) begin failures++; $display("FAIL lh0a_rdata got=%h exp=ffff8000", rdata); end

    do_access(1'b0, F3_LBU, 32'h09, 32'h0);
    checks++; if (rdata !== 32'h000000FF) begin failures++; $display("FAIL lbu09_rdata got=%h exp=000000ff", rdata); end

    do_access(1'b0, F3_LW, 32'h108, 32'h0);
    checks++; if (rdata !== 32'h8000FF19) begin failures++; $display("FAIL lw_wrap_rdata got=%h exp=8000ff19", rdata); end

    do_access(1'b0, F3_LHU, 32'h0A, 32'h0);
    checks++; if (rdata !== 32'h00008000) begin failures++; $display("FAIL lhu0a_rdata got=%h exp=00008000", rdata); end
    checks++; if (r_overlap !== 1'b0) begin failures++; $display("FAIL load_overlap got=%b exp=0", r_overlap); end
  endtask

  task automatic test_errors();
    do_access(1'b0, F3_LW, 32'h06, 32'h0);
    checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL lw06_err got=%b exp=1", r_err); end
    checks++; if (r_lat !== 1) begin failures++; $display("FAIL lw06_latency got=%0d exp=1", r_lat); end
    checks++; if (r_nrd !== 0 || r_nwr !== 0) begin failures++; $display("FAIL lw06_strobes got rd=%0d wr=%0d exp rd=0 wr=0", r_nrd, r_nwr); end
    checks++; if (rdata !== 32'h00008000) begin failures++; $display("FAIL lw06_rdata got=%h exp=00008000", rdata); end

    do_access(1'b0, F3_LH, 32'h09, 32'h0);
    checks++; if (r_err !== 1'b1 || r_nrd !== 0) begin failures++; $display("FAIL lh09_err got err=%b rd=%0d exp err=1 rd=0", r_err, r_nrd); end

    do_access(1'b0, 3'b110, 32'h08, 32'h0);
    checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL load_f3_110_err got=%b exp=1", r_err); end

    do_access(1'b1, 3'b100, 32'h08, 32'h55);
    checks++; if (r_err !== 1'b1 || r_nwr !== 0) begin failures++; $display("FAIL store_f3_100_err got err=%b wr=%0d exp err=1 wr=0", r_err, r_nwr); end
    checks++; if (mem[2] !== 32'h8000FF19) begin failures++; $display("FAIL store_err_mem got=%h exp=8000ff19", mem[2]); end

    @(negedge clk);
    checks++; if (err !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL err_after_done got err=%b done=%b exp 0 0", err, done); end
  endtask

  task automatic test_rmw_reset();
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = F3_SH; addr = 32'h04; wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL sh_access_read got=%b exp=1", mem_read); end
    @(negedge clk);
    checks++; if (mem_write !== 1'b1 || mem_wdata !== 32'h1122BEEF) begin failures++; $display("FAIL sh_rmw_write got we=%b data=%h exp we=1 data=1122beef", mem_write, mem_wdata); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, err, mem_read, mem_write} !== 5'b0) begin failures++; $display("FAIL rmw_reset_flags got=%b exp=00000", {busy, done, err, mem_read, mem_write}); end
    checks++; if (mem_addr !== 6'd0 || mem_wdata !== 32'd0 || rdata !== 32'd0) begin failures++; $display("FAIL rmw_reset_data got addr=%h wdata=%h rdata=%h exp all 0", mem_addr, mem_wdata, rdata); end
    @(posedge clk);
    #1;
    checks++; if (mem[1] !== 32'h11223344) begin failures++; $display("FAIL rmw_reset_mem got=%h exp=11223344", mem[1]); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmw_reset_done got=%b exp=0", done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_byte();
    do_access(1'b1, F3_SB, 32'h05, 32'h000000AB);
    checks++; if (r_lat !== 3) begin failures++; $display("FAIL sb05_latency got=%0d exp=3", r_lat); end
    checks++; if (r_nrd !== 1 || r_nwr !== 1) begin failures++; $display("FAIL sb05_strobes got rd=%0d wr=%0d exp rd=1 wr=1", r_nrd, r_nwr); end
    checks++; if (r_waddr !== 6'd1 || r_wdata !== 32'h1122AB44) begin failures++; $display("FAIL sb05_write got addr=%h data=%h exp addr=01 data=1122ab44", r_waddr, r_wdata); end
    checks++; if (mem[1] !== 32'h1122AB44) begin failures++; $display("FAIL sb05_mem got=%h exp=1122ab44", mem[1]); end
    checks++; if (rdata !== 32'd0 || r_err !== 1'b0 || r_overlap !== 1'b0) begin failures++; $display("FAIL sb05_side got rdata=%h err=%b ovl=%b exp 0 0 0", rdata, r_err, r_overlap); end
  endtask

  task automatic test_store_word();
    do_access(1'b1, F3_SW, 32'h08, 32'hCAFEF00D);
    checks++; if (r_lat !== 2 || r_nrd !== 0 || r_nwr !== 1) begin failures++; $display("FAIL sw08_timing got lat=%0d rd=%0d wr=%0d exp 2 0 1", r_lat, r_nrd, r_nwr); end
    checks++; if (mem[2] !== 32'hCAFEF00D) begin failures++; $display("FAIL sw08_mem got=%h exp=cafef00d", mem[2]); end
    do_access(1'b0, F3_LW, 32'h08, 32'h0);
    checks++; if (rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL sw08_readback got=%h exp=cafef00d", rdata); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_busy;
    logic [5:0] exp_done;
    int n_done;
    exp_busy = 6'b110110;
    exp_done = 6'b010010;
    n_done   = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = F3_LW; addr = 32'h04; wdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) n_done++;
      checks++;
      if (busy !== exp_busy[5-i] || done !== exp_done[5-i]) begin
        failures++;
        $display("FAIL b2b_cycle%0d got busy=%b done=%b exp busy=%b done=%b", i, busy, done, exp_busy[5-i], exp_done[5-i]);
      end
    end
    req = 1'b0;
    checks++; if (n_done !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
    checks++; if (rdata !== 32'h1122AB44) begin failures++; $display("FAIL b2b_rdata got=%h exp=1122ab44", rdata); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got busy=%b exp=0", busy); end
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[2] = 32'h8000FF19;
    mem[1] = 32'h11223344;
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    test_reset();
    test_loads();
    test_errors();
    test_rmw_reset();
    test_store_byte();
    test_store_word();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
